// File: rtl/nes_pkg.sv
// Shared op codes, controller state encoding and status word layout for the
// NES host-to-CPU control bridge.
package nes_pkg;

    localparam logic [7:0] OP_RESET_CPU = 8'd0;
    localparam logic [7:0] OP_START_CPU = 8'd1;
    localparam logic [7:0] OP_PAUSE_CPU = 8'd2;
    localparam logic [7:0] OP_WRITE_MEM = 8'd3;
    localparam logic [7:0] OP_READ_MEM  = 8'd4;
    localparam logic [7:0] OP_STEP_CPU  = 8'd5;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_HALT = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3
    } ctrl_state_t;

    // Bit offsets inside the status byte that sits above the readback payload.
    localparam int STAT_STATE_LSB = 5;
    localparam int STAT_BUSY_BIT  = 4;

    function automatic logic [7:0] status_byte(input ctrl_state_t st, input logic busy);
        logic [7:0] s;
        s = '0;
        s[STAT_STATE_LSB +: 3] = st;
        s[STAT_BUSY_BIT]       = busy;
        return s;
    endfunction

endpackage

// File: rtl/nes_step_counter.sv
// Remaining-instruction counter for single-step mode: load, clear, and
// decrement on each accepted opcode fetch, saturating at zero.
module nes_step_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nes_host_ctrl.sv
// Host-to-CPU control bridge: decodes host commands into CPU run control and
// shares one synchronous memory port between host and CPU, host first.
module nes_host_ctrl
    import nes_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int RESET_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W+7:0]   writedata,
    output logic [DATA_W+7:0]   readdata,
    output logic                cpu_reset,
    output logic                cpu_ready,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_dout,
    input  logic                cpu_write,
    input  logic                cpu_sync,
    output logic [DATA_W-1:0]   cpu_din,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    ctrl_state_t       state, state_d;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_d;

    logic              cs_wr, cs_wr_q, cmd_fire;
    logic [7:0]        op;
    logic [DATA_W-1:0] payload;
    logic              reset_fire, host_fire;
    logic              host_own, own_rd, rd_wait, busy;
    logic [DATA_W-1:0] rd_data;

    logic              step_load, step_clr, step_dec, step_zero;
    logic [DATA_W-1:0] step_cnt;

    // Host handshake: a command is taken on the first cycle chipselect&&write
    // is seen high; holding the strobe never re-issues it. Memory ops have no
    // ready back-pressure -- the host polls busy and ops arriving while busy
    // are dropped.
    assign cs_wr    = chipselect && write;
    assign cmd_fire = cs_wr && !cs_wr_q;
    assign op       = writedata[DATA_W+7:DATA_W];
    assign payload  = writedata[DATA_W-1:0];

    assign reset_fire = cmd_fire && (op == OP_RESET_CPU);
    assign busy       = host_own || rd_wait;
    assign host_fire  = cmd_fire && ((op == OP_WRITE_MEM) || (op == OP_READ_MEM))
                        && (state != ST_RST) && !busy;

    assign cpu_reset = (state == ST_RST);
    assign cpu_ready = ((state == ST_RUN) || (state == ST_STEP)) && !host_own;
    assign cpu_din   = mem_rdata;
    assign step_dec  = (state == ST_STEP) && cpu_sync && cpu_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RST;
            rst_cnt <= '0;
        end else begin
            state   <= state_d;
            rst_cnt <= rst_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        step_load = 1'b0;
        step_clr  = 1'b0;

        case (state)
            ST_RST: begin
                if (rst_cnt == RC_LAST) begin
                    state_d   = ST_HALT;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            ST_STEP: begin
                // A fetch seen with nothing left to count is the final one.
                if (step_dec && step_zero) state_d = ST_HALT;
            end
            default: ;
        endcase

        if (cmd_fire) begin
            case (op)
                OP_RESET_CPU: begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                    step_clr  = 1'b1;
                end
                OP_START_CPU: begin
                    if (state == ST_HALT || state == ST_STEP) state_d = ST_RUN;
                end
                OP_PAUSE_CPU: begin
                    if (state == ST_RUN || state == ST_STEP) begin
                        state_d  = ST_HALT;
                        step_clr = 1'b1;
                    end
                end
                OP_STEP_CPU: begin
                    if (state == ST_HALT || state == ST_STEP) begin
                        state_d   = ST_STEP;
                        step_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    nes_step_counter #(.W(DATA_W)) u_step (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (step_clr),
        .load     (step_load),
        .load_val (payload),
        .dec      (step_dec),
        .cnt      (step_cnt),
        .zero     (step_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_wr_q  <= 1'b0;
            host_own <= 1'b0;
            own_rd   <= 1'b0;
            rd_wait  <= 1'b0;
            rd_data  <= '0;
        end else begin
            cs_wr_q <= cs_wr;
            if (reset_fire) begin
                host_own <= 1'b0;
                own_rd   <= 1'b0;
                rd_wait  <= 1'b0;
            end else begin
                host_own <= host_fire;
                own_rd   <= host_fire && (op == OP_READ_MEM);
                rd_wait  <= host_own && own_rd;
                if (rd_wait) rd_data <= mem_rdata;
            end
        end
    end

    // The CPU write of the command cycle is suppressed on a CPU reset so no
    // write pulse escapes into the reset period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (host_fire) begin
            mem_addr  <= address;
            mem_we    <= (op == OP_WRITE_MEM);
            mem_wdata <= payload;
        end else begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_write && cpu_ready && !reset_fire;
            mem_wdata <= cpu_dout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (chipselect && read) begin
            readdata <= {status_byte(state, busy), rd_data};
        end
    end

endmodule

// File: tb/tb_nes_host_ctrl.sv
// Directed bench for nes_host_ctrl: inputs are driven and outputs sampled on
// the falling clock edge; a small synchronous memory answers the memory port.
module tb_nes_host_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [15:0] address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        cpu_reset, cpu_ready;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_write, cpu_sync;
    logic [7:0]  cpu_din;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] tb_mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    nes_host_ctrl #(.DATA_W(8), .ADDR_W(16), .RESET_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .cpu_reset  (cpu_reset),
        .cpu_ready  (cpu_ready),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_write  (cpu_write),
        .cpu_sync   (cpu_sync),
        .cpu_din    (cpu_din),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_cmd(input logic [7:0] op, input logic [7:0] pl, input logic [15:0] addr);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = {op, pl};
        address    = addr;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic host_read(output logic [15:0] rd);
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        rd         = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        int cnt, wec, syncs;

        reset = 1'b0;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0;
        cpu_addr = '0; cpu_dout = '0; cpu_write = 1'b0; cpu_sync = 1'b0;

        // Reset values and release timing
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_readdata", readdata, 0);
        reset = 1'b1;
        #1;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cpu_reset) break;
            cnt++;
        end
        check("rst_hold_cycles", cnt, 4);
        check("halt_ready", cpu_ready, 0);
        host_read(rd);
        check("halt_status", rd, 16'h2000);

        // Host write then host readback
        host_cmd(8'h03, 8'hA5, 16'h8000);
        check("hwr_we", mem_we, 1);
        check("hwr_addr", mem_addr, 16'h8000);
        check("hwr_wdata", mem_wdata, 8'hA5);
        @(negedge clk);
        check("hwr_we_one_cycle", mem_we, 0);
        host_cmd(8'h04, 8'h00, 16'h8000);
        check("hrd_no_we", mem_we, 0);
        check("hrd_addr", mem_addr, 16'h8000);
        host_read(rd);
        check("hrd_busy_status", rd, 16'h3000);
        for (int i = 0; i < 10; i++) begin
            host_read(rd);
            if (!rd[12]) break;
        end
        check("hrd_readback", rd, 16'h20A5);
        cpu_addr = 16'h8000;
        repeat (2) @(negedge clk);
        check("cpu_din_pass", cpu_din, 8'hA5);

        // Run, CPU writes, host write stealing one cycle
        host_cmd(8'h01, 8'h00, 16'h0000);
        check("run_ready", cpu_ready, 1);
        cpu_write = 1'b1; cpu_addr = 16'h0123; cpu_dout = 8'h5A;
        @(negedge clk);
        check("cpu_wr_we", mem_we, 1);
        check("cpu_wr_addr", mem_addr, 16'h0123);
        check("cpu_wr_data", mem_wdata, 8'h5A);
        cpu_addr = 16'h0200; cpu_dout = 8'h77;
        host_cmd(8'h03, 8'h3C, 16'h9000);
        check("steal_ready", cpu_ready, 0);
        check("steal_we", mem_we, 1);
        check("steal_addr", mem_addr, 16'h9000);
        check("steal_wdata", mem_wdata, 8'h3C);
        @(negedge clk);
        check("steal_ready_back", cpu_ready, 1);
        check("steal_cpu_we_gap", mem_we, 0);
        @(negedge clk);
        check("resume_cpu_we", mem_we, 1);
        check("resume_cpu_addr", mem_addr, 16'h0200);
        check("resume_cpu_data", mem_wdata, 8'h77);
        cpu_write = 1'b0;
        host_read(rd);
        check("run_status", rd, 16'h40A5);

        // Pause, then counted single step
        host_cmd(8'h02, 8'h00, 16'h0000);
        check("pause_ready", cpu_ready, 0);
        check("pause_step_cnt", dut.step_cnt, 0);
        @(negedge clk);
        host_cmd(8'h05, 8'h02, 16'h0000);
        check("step_ready", cpu_ready, 1);
        check("step_load", dut.step_cnt, 2);
        syncs = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) check("step_cnt_1", dut.step_cnt, 1);
            if (k == 6) check("step_cnt_0", dut.step_cnt, 0);
            if (k == 8) check("step_last_ready", cpu_ready, 1);
            if (k == 9) check("step_done_ready", cpu_ready, 0);
            cpu_sync = (k == 2) || (k == 5) || (k == 8) || (k == 10);
            if (cpu_sync && cpu_ready) syncs++;
            @(negedge clk);
        end
        cpu_sync = 1'b0;
        check("step_sync_count", syncs, 3);
        host_read(rd);
        check("step_halt_status", rd, 16'h20A5);

        // Pause mid-step, then CPU reset mid-run
        host_cmd(8'h05, 8'h07, 16'h0000);
        check("step7_load", dut.step_cnt, 7);
        @(negedge clk);
        host_cmd(8'h02, 8'h00, 16'h0000);
        check("pause_mid_step_ready", cpu_ready, 0);
        check("pause_mid_step_cnt", dut.step_cnt, 0);
        host_read(rd);
        check("pause_mid_step_status", rd, 16'h20A5);
        host_cmd(8'h01, 8'h00, 16'h0000);
        cpu_write = 1'b1; cpu_addr = 16'h0300; cpu_dout = 8'h11;
        @(negedge clk);
        host_cmd(8'h00, 8'h00, 16'h0000);
        cnt = cpu_reset ? 1 : 0;
        wec = mem_we ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_reset) cnt++;
            if (mem_we) wec++;
        end
        cpu_write = 1'b0;
        check("cpu_rst_cycles", cnt, 4);
        check("cpu_rst_no_we", wec, 0);
        host_read(rd);
        check("cpu_rst_halt_status", rd, 16'h20A5);

        // START during RST is ignored
        host_cmd(8'h00, 8'h00, 16'h0000);
        @(negedge clk);
        host_cmd(8'h01, 8'h00, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            if (!cpu_reset) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        host_read(rd);
        check("rst_ignores_start", rd, 16'h20A5);

        // Held strobe is accepted once
        chipselect = 1'b1; write = 1'b1; writedata = 16'h0342; address = 16'h8001;
        wec = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) wec++;
        end
        chipselect = 1'b0; write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_we) wec++;
        end
        check("held_write_once", wec, 1);
        host_cmd(8'h04, 8'h00, 16'h8001);
        for (int i = 0; i < 10; i++) begin
            host_read(rd);
            if (!rd[12]) break;
        end
        check("held_write_readback", rd, 16'h2042);
        chipselect = 1'b1; write = 1'b1; writedata = 16'h0100;
        repeat (5) @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        host_read(rd);
        check("held_start_run", rd, 16'h4042);

        // Unknown op, then simultaneous read and write
        host_cmd(8'h7F, 8'h00, 16'h8000);
        check("unknown_no_we", mem_we, 0);
        host_read(rd);
        check("unknown_no_change", rd, 16'h4042);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; writedata = 16'h0200;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        check("simul_pre_state", readdata, 16'h4042);
        host_read(rd);
        check("simul_pause", rd, 16'h2042);

        // Asynchronous reset during a host read
        host_cmd(8'h04, 8'h00, 16'h8000);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 0);
        check("async_rst_cpu_reset", cpu_reset, 1);
        check("async_rst_we", mem_we, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_ready", cpu_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
